// File: rtl/audio_pkg.sv
// Shared types, helpers and parameter-legality macros for the audio transmit path.
`ifndef AUDIO_PKG_SV
`define AUDIO_PKG_SV

// Sample must fit inside its slot.
`define AUDIO_DATA_W_OK(dw, sw) (((dw) >= 1) && ((dw) <= (sw)))
// FIFO depth must be a power of two, at least two frames.
`define AUDIO_DEPTH_OK(d) (((d) >= 2) && ((((d) - 1) & (d)) == 0))
// Bit clock half-period must be at least one system clock.
`define AUDIO_BCLK_HALF_OK(bh) ((bh) >= 1)

package audio_pkg;

    // Serial format: I2S delays the MSB one BCLK behind the LRCK edge.
    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    // Number of BCLK periods in one stereo frame.
    function automatic int unsigned frame_w(input int unsigned slot_w);
        return 2 * slot_w;
    endfunction

endpackage

`endif

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO: registered ready/level, read data valid in the pop cycle.
module audio_frame_fifo
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data_c,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_d;
    logic             push_ok;
    logic             pop_ok;

    // Head of queue is presented combinationally so the consumer sees it as it pops.
    assign rd_data_c = mem[rd_ptr];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        push_ok  = push && ready;
        pop_ok   = pop && (level != '0);
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        level_d  = level;
        if (push_ok) begin
            wr_ptr_d = wr_ptr + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level + 1'b1;
            2'b01:   level_d = level - 1'b1;
            default: level_d = level;
        endcase
    end

    // Storage array; contents need no reset since level tracks validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, level and ready; ready is derived from next level so it stays exact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            level  <= level_d;
            ready  <= (level_d != LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified transmitter, BCLK and LRCK master for the WM8731 DAC.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BCLK_HALF = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   fmt,
    input  logic                   wr_valid,
    input  logic [2*DATA_W-1:0]    wr_data,
    output logic                   wr_ready,
    input  logic                   clear_underrun,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   aud_bclk,
    output logic                   aud_daclrck,
    output logic                   aud_dacdat
);

    localparam int unsigned FRAME_W = frame_w(SLOT_W);
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned PAD_W   = SLOT_W - DATA_W;

    // Elaboration-time legality checks.
    if (!(`AUDIO_DATA_W_OK(DATA_W, SLOT_W))) begin : g_chk_data_w
        $error("audio_i2s_tx: DATA_W must be in 1..SLOT_W");
    end
    if (!(`AUDIO_DEPTH_OK(DEPTH))) begin : g_chk_depth
        $error("audio_i2s_tx: DEPTH must be a power of two and >= 2");
    end
    if (!(`AUDIO_BCLK_HALF_OK(BCLK_HALF))) begin : g_chk_bclk_half
        $error("audio_i2s_tx: BCLK_HALF must be >= 1");
    end

    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [BIT_W-1:0]    bitcnt_q;
    logic [BIT_W-1:0]    bitcnt_d;
    logic                bclk_d;
    logic                lrck_d;
    logic                dat_d;
    logic [FRAME_W-1:0]  sh_q;
    logic [FRAME_W-1:0]  sh_d;
    logic                und_d;
    fmt_e                fmt_q;
    fmt_e                fmt_d;
    logic [FRAME_W-1:0]  frame_c;
    logic                pop_c;
    logic                set_und_c;
    logic                fifo_empty_c;
    logic [2*DATA_W-1:0] fifo_rd_c;
    logic [SLOT_W-1:0]   slot_l_c;
    logic [SLOT_W-1:0]   slot_r_c;

    audio_frame_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop_c),
        .rd_data_c (fifo_rd_c),
        .ready     (wr_ready),
        .level     (fifo_level)
    );

    // Left-align each channel sample inside its slot, padding LSBs with zeros.
    assign slot_l_c     = SLOT_W'(fifo_rd_c[2*DATA_W-1 -: DATA_W]) << PAD_W;
    assign slot_r_c     = SLOT_W'(fifo_rd_c[DATA_W-1:0]) << PAD_W;
    assign fifo_empty_c = (fifo_level == '0);

    // Divider, bit counter, LRCK, frame load/shift and underrun next-state.
    always_comb begin
        div_d     = div_q;
        bitcnt_d  = bitcnt_q;
        bclk_d    = aud_bclk;
        lrck_d    = aud_daclrck;
        dat_d     = aud_dacdat;
        sh_d      = sh_q;
        fmt_d     = fmt_q;
        frame_c   = '0;
        pop_c     = 1'b0;
        set_und_c = 1'b0;

        if (!enable) begin
            div_d    = '0;
            bitcnt_d = BIT_W'(FRAME_W - 1);
            bclk_d   = 1'b0;
            lrck_d   = 1'b0;
            dat_d    = 1'b0;
            sh_d     = '0;
            fmt_d    = fmt_e'(fmt);
        end else if (div_q == DIV_W'(BCLK_HALF - 1)) begin
            div_d  = '0;
            bclk_d = ~aud_bclk;
            if (aud_bclk) begin
                // Fall event: advance bit position and present the next data bit.
                bitcnt_d = (bitcnt_q == BIT_W'(FRAME_W - 1)) ? '0 : bitcnt_q + 1'b1;
                if (bitcnt_d == '0) begin
                    if (fifo_empty_c) begin
                        set_und_c = 1'b1;
                    end else begin
                        frame_c = {slot_l_c, slot_r_c};
                        pop_c   = 1'b1;
                    end
                end else begin
                    frame_c = sh_q;
                end
                dat_d = frame_c[FRAME_W-1];
                sh_d  = frame_c << 1;

                if (fmt_q == FMT_LJ) begin
                    if (bitcnt_d == '0) begin
                        lrck_d = 1'b0;
                    end else if (bitcnt_d == BIT_W'(SLOT_W)) begin
                        lrck_d = 1'b1;
                    end
                end else begin
                    if (bitcnt_d == BIT_W'(FRAME_W - 1)) begin
                        lrck_d = 1'b0;
                    end else if (bitcnt_d == BIT_W'(SLOT_W - 1)) begin
                        lrck_d = 1'b1;
                    end
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        // A new underrun outranks a simultaneous clear request.
        und_d = set_und_c | (underrun & ~clear_underrun);
    end

    // State and pin registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            bitcnt_q    <= BIT_W'(FRAME_W - 1);
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            sh_q        <= '0;
            underrun    <= 1'b0;
            fmt_q       <= FMT_I2S;
        end else begin
            div_q       <= div_d;
            bitcnt_q    <= bitcnt_d;
            aud_bclk    <= bclk_d;
            aud_daclrck <= lrck_d;
            aud_dacdat  <= dat_d;
            sh_q        <= sh_d;
            underrun    <= und_d;
            fmt_q       <= fmt_d;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: frame-bit table, directed corner cases, random run vs. a timing model.
module tb_audio_i2s_tx;

    localparam int BH    = 2;
    localparam int SW    = 32;
    localparam int FW    = 64;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        fmt;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        clear_underrun;
    logic        underrun;
    logic [2:0]  fifo_level;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    audio_i2s_tx #(
        .DATA_W    (16),
        .SLOT_W    (SW),
        .DEPTH     (DEPTH),
        .BCLK_HALF (BH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .fmt            (fmt),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .clear_underrun (clear_underrun),
        .underrun       (underrun),
        .fifo_level     (fifo_level),
        .aud_bclk       (aud_bclk),
        .aud_daclrck    (aud_daclrck),
        .aud_dacdat     (aud_dacdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected bits of the {A55A, 8001} frame at selected bit positions.
    typedef struct {
        int p;
        bit lrck_i2s;
        bit lrck_lj;
        bit dat;
    } bit_vec_t;
    bit_vec_t tbl [16];

    logic [31:0] ff [5];

    // Behavioural model: time since enable, queue of frames, current frame bits.
    int          m_n;
    logic [31:0] m_q [$];
    logic [63:0] m_cur;
    bit          m_bclk, m_lrck, m_dat, m_und, m_ready, m_fmt, m_fall;
    int          m_level;
    int          m_p;

    function automatic logic [63:0] expand(input logic [31:0] fr);
        return {fr[31:16], 16'h0000, fr[15:0], 16'h0000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_n = -1;
        m_q.delete();
        m_cur = '0;
        m_bclk = 0; m_lrck = 0; m_dat = 0; m_und = 0; m_ready = 0; m_fmt = 0; m_fall = 0;
        m_level = 0;
        m_p = 0;
    endtask

    // One clk edge of the model, derived from elapsed time since enable.
    task automatic model_edge();
        bit push;
        bit set;
        push   = wr_valid && m_ready;
        set    = 0;
        m_fall = 0;
        if (!enable) begin
            m_n = -1;
            m_fmt = fmt;
            m_bclk = 0; m_lrck = 0; m_dat = 0;
        end else begin
            m_n++;
            m_bclk = (((m_n + 1) / BH) % 2) == 1;
            if (((m_n + 1) % (2 * BH)) == 0) begin
                m_fall = 1;
                m_p = (((m_n + 1) / (2 * BH)) - 1) % FW;
                if (m_p == 0) begin
                    if (m_q.size() > 0) m_cur = expand(m_q.pop_front());
                    else begin
                        m_cur = '0;
                        set = 1;
                    end
                end
                m_dat  = m_cur[FW-1-m_p];
                m_lrck = m_fmt ? (m_p >= SW) : ((m_p >= SW - 1) && (m_p <= FW - 2));
            end
        end
        if (push) m_q.push_back(wr_data);
        m_und   = set ? 1'b1 : (clear_underrun ? 1'b0 : m_und);
        m_level = m_q.size();
        m_ready = (m_level != DEPTH);
    endtask

    task automatic compare_all();
        check("bclk",     32'(aud_bclk),    32'(m_bclk));
        check("lrck",     32'(aud_daclrck), 32'(m_lrck));
        check("dacdat",   32'(aud_dacdat),  32'(m_dat));
        check("underrun", 32'(underrun),    32'(m_und));
        check("wr_ready", 32'(wr_ready),    32'(m_ready));
        check("level",    32'(fifo_level),  32'(m_level));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic run_until_n(input int target);
        int guard;
        guard = 0;
        while (m_n < target && guard < 5000) begin
            step();
            guard++;
        end
        if (m_n < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_until_n: reached %0d required %0d", m_n, target);
        end
    endtask

    task automatic check_pins_zero(input string tag);
        check({tag, "_bclk"}, 32'(aud_bclk),    32'd0);
        check({tag, "_lrck"}, 32'(aud_daclrck), 32'd0);
        check({tag, "_dat"},  32'(aud_dacdat),  32'd0);
    endtask

    // Push one known frame, enable, and check table bit positions in the first frame.
    task automatic frame_test(input bit f);
        enable = 0; step();
        wr_valid = 1; wr_data = 32'hA55A_8001; fmt = f; step();
        wr_valid = 0; step();
        enable = 1;
        for (int s = 0; s < 256; s++) begin
            step();
            if (m_n == 1) check("first_rise", 32'(aud_bclk), 32'd1);
            if (m_fall && m_n < 256) begin
                for (int i = 0; i < 16; i++) begin
                    if (tbl[i].p == m_p) begin
                        check($sformatf("tbl_dat_f%0d_p%0d", f, m_p), 32'(aud_dacdat), 32'(tbl[i].dat));
                        check($sformatf("tbl_lrck_f%0d_p%0d", f, m_p), 32'(aud_daclrck),
                              32'(f ? tbl[i].lrck_lj : tbl[i].lrck_i2s));
                    end
                end
            end
        end
        enable = 0; step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0,  0, 0, 1};
        tbl[1]  = '{1,  0, 0, 0};
        tbl[2]  = '{2,  0, 0, 1};
        tbl[3]  = '{3,  0, 0, 0};
        tbl[4]  = '{4,  0, 0, 0};
        tbl[5]  = '{5,  0, 0, 1};
        tbl[6]  = '{15, 0, 0, 0};
        tbl[7]  = '{16, 0, 0, 0};
        tbl[8]  = '{30, 0, 0, 0};
        tbl[9]  = '{31, 1, 0, 0};
        tbl[10] = '{32, 1, 1, 1};
        tbl[11] = '{33, 1, 1, 0};
        tbl[12] = '{47, 1, 1, 1};
        tbl[13] = '{48, 1, 1, 0};
        tbl[14] = '{62, 1, 1, 0};
        tbl[15] = '{63, 0, 1, 0};

        ff[0] = 32'hC0DE_1234;
        ff[1] = 32'h9357_2468;
        ff[2] = 32'h8BAD_F00D;
        ff[3] = 32'h0F0F_F0F0;
        ff[4] = 32'hFFFF_FFFF;

        reset_n = 0; enable = 0; fmt = 0; wr_valid = 0; wr_data = '0; clear_underrun = 0;
        reset_model();
        step(); step(); step();
        check("reset_ready", 32'(wr_ready), 32'd0);
        reset_n = 1;
        step();
        check("post_reset_ready", 32'(wr_ready),   32'd1);
        check("post_reset_level", 32'(fifo_level), 32'd0);
        check("post_reset_und",   32'(underrun),   32'd0);

        frame_test(0);
        frame_test(1);

        // Underrun with empty FIFO, clear priority.
        clear_underrun = 1; step(); clear_underrun = 0; step();
        check("und_cleared", 32'(underrun), 32'd0);
        enable = 1;
        run_until_n(2);
        check("und_before_load", 32'(underrun), 32'd0);
        step();
        check("und_after_load", 32'(underrun), 32'd1);
        run_until_n(10);
        clear_underrun = 1; step(); clear_underrun = 0;
        check("und_clear_alone", 32'(underrun), 32'd0);
        run_until_n(258);
        clear_underrun = 1; step(); clear_underrun = 0;
        check("und_set_beats_clear", 32'(underrun), 32'd1);
        step();
        clear_underrun = 1; step(); clear_underrun = 0;
        check("und_clear_again", 32'(underrun), 32'd0);
        enable = 0; step();

        // Full FIFO while idle, then pop-to-ready latency.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_data = ff[i]; step();
            if (i == 3) begin
                check("full_ready",  32'(wr_ready),   32'd0);
                check("full_level",  32'(fifo_level), 32'd4);
            end
        end
        wr_valid = 0; step();
        check("fifth_dropped_level", 32'(fifo_level), 32'd4);
        enable = 1;
        run_until_n(2);
        check("ready_before_pop", 32'(wr_ready), 32'd0);
        step();
        check("ready_after_pop", 32'(wr_ready),   32'd1);
        check("level_after_pop", 32'(fifo_level), 32'd3);
        check("first_msb",       32'(aud_dacdat), 32'(ff[0][31]));

        // Disable mid-frame at bitcnt 20 (BCLK high), then restart from a fresh frame.
        run_until_n(85);
        check("mid_bclk_high", 32'(aud_bclk), 32'd1);
        enable = 0; step();
        check_pins_zero("disable");
        check("disable_level", 32'(fifo_level), 32'd3);
        enable = 1;
        run_until_n(3);
        check("restart_lrck", 32'(aud_daclrck), 32'd0);
        check("restart_msb",  32'(aud_dacdat),  32'(ff[1][31]));
        check("restart_level", 32'(fifo_level), 32'd2);
        run_until_n(800);
        check("drain_underrun", 32'(underrun),   32'd1);
        check("drain_level",    32'(fifo_level), 32'd0);
        enable = 0; step();

        // Randomised traffic checked cycle by cycle against the model.
        for (int s = 0; s < 4000; s++) begin
            int rate;
            rate = (s < 2000) ? 20 : 2;
            wr_valid       = ($urandom_range(0, 999) < rate);
            wr_data        = $urandom;
            clear_underrun = ($urandom_range(0, 199) == 0);
            fmt            = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) enable = ~enable;
            else if (s == 10) enable = 1;
            step();
        end
        wr_valid = 0; clear_underrun = 0;

        // Asynchronous reset in the middle of a run.
        enable = 1;
        wr_valid = 1; wr_data = 32'h1111_2222; step(); wr_valid = 0;
        run_until_n(m_n + 6);
        #1;
        reset_n = 0;
        #1;
        check_pins_zero("async_reset");
        check("async_reset_und",   32'(underrun),   32'd0);
        check("async_reset_ready", 32'(wr_ready),   32'd0);
        check("async_reset_level", 32'(fifo_level), 32'd0);
        reset_model();
        step(); step();
        reset_n = 1; enable = 0;
        step();
        check("rerelease_ready", 32'(wr_ready),   32'd1);
        check("rerelease_level", 32'(fifo_level), 32'd0);
        check("rerelease_und",   32'(underrun),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Parametrised stereo I2S/left-justified transmitter that drives the WM8731 DAC pins (AUD_BCLK, AUD_DACLRCK, AUD_DACDAT) directly from fabric. It replaces the fixed-format audio IP path in the soc_system integration, adding selectable sample and slot widths, a frame FIFO with a ready/valid write side for the HPS bridge, a run-time format select, and underrun reporting. The codec operates as a clock slave; this block is the bit- and frame-clock master.

## Interface
- DATA_W, 16: bits per channel sample; must satisfy DATA_W ≤ SLOT_W.
- SLOT_W, 32: BCLK periods per channel slot; a frame is 2*SLOT_W periods.
- DEPTH, 64: FIFO depth in stereo frames; must be a power of two and ≥ 2.
- BCLK_HALF, 8: clk cycles per BCLK half-period; must be ≥ 1.
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run serializer; 0 = idle.
- fmt  in  1  format: 0 = I2S, 1 = left-justified; sampled only while enable = 0.
- wr_valid  in  1  frame write request.
- wr_data  in  2*DATA_W  {left, right}; left channel in the upper half.
- wr_ready  out  1  FIFO can accept a frame.
- clear_underrun  in  1  single-cycle pulse; clears the sticky underrun flag.
- underrun  out  1  sticky; set when a frame boundary occurs with the FIFO empty.
- fifo_level  out  $clog2(DEPTH)+1  number of stored frames.
- aud_bclk, aud_daclrck, aud_dacdat  out  1 each  codec pins.

## Operation
- **Reset values:** all outputs 0 except wr_ready, which is 0 during reset and 1 on the first cycle after release. FIFO empty, underrun = 0, bitcnt = 2*SLOT_W-1.
- **Write side:** a push occurs when wr_valid && wr_ready. wr_ready = (fifo_level != DEPTH) and is registered, with no combinational path from the pop side. A push and a pop in the same cycle leave fifo_level unchanged.
- **Idle (enable = 0):**
  - aud_bclk, aud_daclrck and aud_dacdat are held at 0.
  - The divider is 0 and bitcnt = 2*SLOT_W-1.
  - The shift register is cleared; the FIFO contents are retained.
  - fmt is latched into a format register.
- **Deassert mid-frame:** dropping enable mid-frame returns the block to idle on the next clk. The in-flight frame is discarded and is not re-queued.
- **Divider:** counts 0..BCLK_HALF-1. At the terminal count aud_bclk toggles. A toggle 1→0 is a *fall event*; a toggle 0→1 is a *rise event*.
- **Fall event:**
  - bitcnt advances mod 2*SLOT_W.
  - If the new bitcnt = 0, the block pops the FIFO and loads the shift register with {left, zeros(SLOT_W-DATA_W), right, zeros(SLOT_W-DATA_W)}.
  - If the FIFO is empty at that point, the block loads all zeros and sets underrun.
  - aud_dacdat takes the shift register MSB and the register shifts left by one.
- **LRCK:** 0 for the left slot, 1 for the right slot.
  - Left-justified: aud_daclrck changes on the fall event where bitcnt becomes 0 or SLOT_W.
  - I2S: aud_daclrck changes one fall event earlier (bitcnt becomes 2*SLOT_W-1 or SLOT_W-1). The MSB therefore trails the LRCK edge by one BCLK.
- **underrun priority:** if set and clear_underrun occur in the same cycle, set wins.

## Timing
- BCLK period is 2*BCLK_HALF clk; frame rate = clk / (4*BCLK_HALF*SLOT_W). Default: 50 MHz → 48.83 kHz.
- The first rise event occurs BCLK_HALF clk after enable rises. The first fall event, which loads the first frame, occurs 2*BCLK_HALF clk after enable rises.
- aud_dacdat and aud_daclrck change only on fall events, so they are stable at every BCLK rising edge.
- Pop-to-ready latency: wr_ready rises on the cycle after a pop from a full FIFO.
- All outputs are registered.

## Structure
- **Shared package `audio_pkg`:**
  - fmt_e enum: FMT_I2S = 0, FMT_LJ = 1.
  - Localparam helper for frame width: 2*SLOT_W.
  - Parameter-check macros for the DATA_W, DEPTH and BCLK_HALF constraints.
- **Sub-module `audio_frame_fifo`:** synchronous FIFO parametrised by width and DEPTH. It provides registered ready and level outputs, and its read data is valid in the cycle of the pop.
- **Top of the block:** divider, bit counter, LRCK generation, shift register and underrun flag.

## Test plan
All scenarios use DATA_W=16, SLOT_W=32, DEPTH=4, BCLK_HALF=2.
- **Reset:** assert reset_n=0 mid-run → all outputs 0 immediately; after release wr_ready=1, fifo_level=0, underrun=0.
- **I2S frame:** push {16'hA55A, 16'h8001}, fmt=0, enable=1 → left slot:
  - aud_daclrck falls one BCLK before the first bit.
  - Bits 1010_0101_0101_1010 follow, then 16 zeros.
  - The right slot starts 1000_0000_0000_0001 one BCLK after LRCK rises.
- **Left-justified:** same data with fmt=1 → MSB 1 on the same fall event as the LRCK transition.
- **Underrun:** enable with an empty FIFO → aud_dacdat=0 for the whole frame and underrun=1 after the first frame load.
  - A clear_underrun pulse in the same cycle as a new underrun leaves underrun=1.
  - A pulse alone clears it.
- **Full FIFO:** with enable=0, push 5 frames → wr_ready=0 after the 4th, fifo_level=4, 5th frame dropped. Then enable → wr_ready=1 one cycle after the first pop.
- **Disable mid-frame:** drop enable at bitcnt=20 → next clk all pins 0, fifo_level unchanged. Re-enable → a fresh frame starts from the left slot.
